fios_res_normalizer: RTL and testbench
======================================

# fios_res_normalizer

Result normalizer and collector placed directly downstream of the last processing element of the FIOS Montgomery multiplier chain. It consumes the per-cycle 34-bit partial result, split into a 17-bit low digit and a 17-bit high part. It resolves the redundant carries digit by digit into canonical 17-bit words and buffers one full S-digit result. It then streams the result out over a valid/ready handshake, LSB digit first.

## Interface
- S, 16: digits per result; S·17 bits ≥ modulus width. Must be ≥ 2.
- CNT_W, $clog2(S): digit index width (derived, not overridable).

Ports:
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse: arm for a new result (clears carry and index).
- digit_valid_i  in  1  digit_i/carry_i valid this cycle.
- digit_i  in  17  low part of the PE result (RES[16:0]).
- carry_i  in  17  high part of the PE result (RES[33:17]), weight 2^17 relative to digit_i.
- res_valid_o  out  1  res_data_o valid.
- res_ready_i  in  1  consumer accepts res_data_o.
- res_data_o  out  17  normalized digit.
- res_last_o  out  1  marks digit index S-1.
- carry_o  out  18  final carry above digit S-1; stable from entry into DRAIN until the next start_i.
- busy_o  out  1  state ≠ IDLE.
- done_o  out  1  one-cycle pulse after the last digit transfers.
- overrun_o  out  1  sticky error flag; cleared only by reset or start_i in IDLE.

## Operation
- Three states: IDLE, COLLECT, DRAIN.
- IDLE:
  - start_i → COLLECT; acc, wr_idx and overrun_o are cleared.
  - digit_valid_i is ignored.
- COLLECT, on each cycle with digit_valid_i:
  - sum[18:0] = digit_i + acc.
  - buf[wr_idx] ← sum[16:0].
  - acc ← carry_i + sum[18:17]. acc is 18 bits wide and never overflows, since the maximum is 0x1FFFF + 3.
  - wr_idx increments.
  - When wr_idx = S-1 is written: go to DRAIN, carry_o ← new acc, rd_idx ← 0.
- COLLECT, start_i: restart. acc and wr_idx are cleared, and a digit presented in the same cycle is dropped.
- DRAIN:
  - res_valid_o = 1 and res_data_o = buf[rd_idx]; res_last_o = (rd_idx = S-1).
  - A transfer occurs when res_valid_o & res_ready_i; rd_idx then increments.
  - A transfer with res_last_o high → IDLE and done_o pulses in the next cycle.
  - digit_valid_i in DRAIN sets overrun_o; the digit is dropped and buf is unchanged.
  - start_i in DRAIN is ignored.
- res_data_o must hold stable while res_valid_o & !res_ready_i.
- The buffer is a plain register array of S×17 bits. There is no read-during-write hazard because COLLECT and DRAIN are exclusive.

## Timing
- Reset values (reset_i low, asynchronous): state IDLE, all outputs 0, acc/wr_idx/rd_idx 0. Buffer contents are don't-care.
- Reset asserted mid-COLLECT or mid-DRAIN aborts immediately. No done_o is produced, and outputs are 0 in the same cycle the reset asserts.
- start_i at edge t → busy_o = 1 from t+1. A digit is first accepted at edge t+1.
- Digits may arrive back-to-back at one per cycle or with gaps; there is no stall output toward the PE chain.
- Last digit written at edge t → res_valid_o = 1 and carry_o valid from t+1 (1-cycle latency).
- With res_ready_i held high, digits drain at one per cycle: S cycles in total, done_o at the edge after the last transfer.
- Minimum period start to done with continuous input and ready: 2S+2 cycles.
- A start_i issued in the same cycle as done_o (state already IDLE) is accepted.

## Test plan
- **Plain result** (S=4): digits 0x1FFFF,0,0,0 with carries 0x00001,0,0,0 → res_data 0x1FFFF, 0x00001, 0, 0; res_last_o on the 4th digit; carry_o 0; done_o one pulse.
- **Worst-case carries** (S=4): digit 0x1FFFF and carry 0x1FFFF on all four → res_data 0x1FFFF, 0x1FFFE, 0x1FFFF, 0x1FFFF; carry_o 0x20000.
- **Back-pressure**: res_ready_i toggled 1,0,0,1,… → each digit appears exactly once and res_data_o is stable during the low cycles; done_o follows the final transfer.
- **Gapped input plus restart**: two digits, then start_i, then 4 fresh digits 1,2,3,4 with carries 0 → output 1,2,3,4; nothing from before the restart appears.
- **Overrun**: digit_valid_i pulsed during DRAIN → overrun_o rises next cycle and stays high; drained data is unchanged. start_i after IDLE clears it.
- **Async reset mid-DRAIN** after 2 of 4 digits → all outputs 0 immediately; the next start plus 4 digits completes normally.

Source files
------------

// File: rtl/fios_res_normalizer.sv
// Result normalizer/collector for the FIOS Montgomery multiplier chain.
// Resolves the redundant {carry, digit} PE outputs into canonical 17-bit words,
// buffers one S-digit result and streams it out LSB digit first.
module fios_res_normalizer #(
    parameter int unsigned S = 16,
    localparam int unsigned CNT_W = $clog2(S)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             digit_valid_i,
    input  logic [16:0]      digit_i,
    input  logic [16:0]      carry_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [16:0]      res_data_o,
    output logic             res_last_o,
    output logic [17:0]      carry_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             overrun_o
);

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(S - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StDrain} state_e;

    state_e            state_q, state_d;
    logic [17:0]       acc_q, acc_d;
    logic [CNT_W-1:0]  wr_idx_q, wr_idx_d;
    logic [CNT_W-1:0]  rd_idx_q, rd_idx_d;
    logic [17:0]       carry_q, carry_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic [16:0]       mem_q [S];

    logic [18:0]       sum;
    logic [17:0]       acc_new;
    logic              mem_we;
    logic              wr_last;
    logic              rd_last;

    // Carry-resolve arithmetic for the incoming digit
    always_comb begin
        sum     = 19'(digit_i) + 19'(acc_q);
        acc_new = 18'(carry_i) + 18'(sum[18:17]);
        wr_last = (wr_idx_q == LastIdx);
        rd_last = (rd_idx_q == LastIdx);
    end

    // State register
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StCollect;
            end
            StCollect: begin
                if (!start_i && digit_valid_i && wr_last) state_d = StDrain;
            end
            StDrain: begin
                if (res_ready_i && rd_last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: accumulator, indices, carry-out and status flags
    always_comb begin
        acc_d     = acc_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        carry_d   = carry_q;
        overrun_d = overrun_q;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    acc_d     = '0;
                    wr_idx_d  = '0;
                    rd_idx_d  = '0;
                    carry_d   = '0;
                    overrun_d = 1'b0;
                end
            end
            StCollect: begin
                // A restart wins over a digit presented in the same cycle
                if (start_i) begin
                    acc_d    = '0;
                    wr_idx_d = '0;
                end else if (digit_valid_i) begin
                    mem_we   = 1'b1;
                    acc_d    = acc_new;
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (wr_last) begin
                        carry_d  = acc_new;
                        rd_idx_d = '0;
                        wr_idx_d = '0;
                    end
                end
            end
            StDrain: begin
                if (digit_valid_i) overrun_d = 1'b1;
                if (res_ready_i) begin
                    rd_idx_d = rd_idx_q + 1'b1;
                    if (rd_last) done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            acc_q     <= '0;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            carry_q   <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            carry_q   <= carry_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // Result buffer; contents need no reset
    always_ff @(posedge clock_i) begin
        if (mem_we) mem_q[wr_idx_q] <= sum[16:0];
    end

    // Outputs decoded from state so an async reset zeroes them at once
    always_comb begin
        busy_o      = (state_q != StIdle);
        res_valid_o = (state_q == StDrain);
        res_data_o  = (state_q == StDrain) ? mem_q[rd_idx_q] : '0;
        res_last_o  = (state_q == StDrain) && rd_last;
        carry_o     = carry_q;
        done_o      = done_q;
        overrun_o   = overrun_q;
    end

endmodule

// File: tb/tb_fios_res_normalizer.sv
// Self-checking bench for fios_res_normalizer (S = 4): table vectors, hand-written
// corner sequences and randomized results checked against a big-integer model.
module tb_fios_res_normalizer;

    localparam int unsigned S = 4;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        start_i = 1'b0;
    logic        digit_valid_i = 1'b0;
    logic [16:0] digit_i = '0;
    logic [16:0] carry_i = '0;
    logic        res_valid_o;
    logic        res_ready_i = 1'b0;
    logic [16:0] res_data_o;
    logic        res_last_o;
    logic [17:0] carry_o;
    logic        busy_o;
    logic        done_o;
    logic        overrun_o;

    fios_res_normalizer #(.S(S)) dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .digit_valid_i (digit_valid_i),
        .digit_i       (digit_i),
        .carry_i       (carry_i),
        .res_valid_o   (res_valid_o),
        .res_ready_i   (res_ready_i),
        .res_data_o    (res_data_o),
        .res_last_o    (res_last_o),
        .carry_o       (carry_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .overrun_o     (overrun_o)
    );

    always #5 clock_i = ~clock_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [16:0] d [4];
        logic [16:0] c [4];
        logic [16:0] w [4];
        logic [17:0] cy;
        int          rmode;
    } vec_t;

    vec_t        tbl [3];
    logic [16:0] cur_d [4];
    logic [16:0] cur_c [4];
    logic [16:0] exp_w [4];
    logic [17:0] exp_c;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    // Whole result as one integer: sum of (digit + carry*2^17) * 2^(17*i)
    function automatic void ref_model();
        logic [127:0] tot;
        tot = '0;
        for (int i = 0; i < 4; i++) begin
            tot = tot + ((128'(cur_d[i]) + (128'(cur_c[i]) << 17)) << (17 * i));
        end
        for (int i = 0; i < 4; i++) exp_w[i] = tot[17*i +: 17];
        exp_c = tot[68 +: 18];
    endfunction

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1);
    endtask

    task automatic send_digit(input logic [16:0] d, input logic [16:0] c);
        digit_valid_i = 1'b1;
        digit_i = d;
        carry_i = c;
        tick();
        digit_valid_i = 1'b0;
    endtask

    task automatic feed(input int gapmode);
        for (int i = 0; i < 4; i++) begin
            if (gapmode != 0) repeat ($urandom_range(0, 2)) tick();
            if (i < 3) check("valid_early", res_valid_o, 0);
            send_digit(cur_d[i], cur_c[i]);
        end
        check("valid_latency", res_valid_o, 1);
        check("carry_out", carry_o, exp_c);
    endtask

    task automatic drain_check(input int rmode);
        int          k = 0;
        bit          held = 0;
        bit          fin = 0;
        bit          r;
        logic [16:0] hd = '0;
        for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
            case (rmode)
                0:       r = 1'b1;
                1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            res_ready_i = r;
            check("res_valid_drain", res_valid_o, 1);
            if (held) check("data_stable", res_data_o, hd);
            check("carry_stable", carry_o, exp_c);
            if (res_valid_o && r) begin
                check($sformatf("res_data[%0d]", k), res_data_o, exp_w[k]);
                check($sformatf("res_last[%0d]", k), res_last_o, (k == 3));
                k++;
                held = 0;
                if (k == 4) fin = 1;
            end else begin
                held = res_valid_o;
                hd = res_data_o;
            end
            tick();
        end
        res_ready_i = 1'b0;
        if (!fin) check("drain_timeout", k, 4);
        check("done_pulse", done_o, 1);
        check("busy_after_done", busy_o, 0);
        check("valid_after_done", res_valid_o, 0);
    endtask

    task automatic run_case(input int rmode, input int gapmode);
        do_start();
        feed(gapmode);
        drain_check(rmode);
    endtask

    task automatic load_vec(input int i);
        for (int j = 0; j < 4; j++) begin
            cur_d[j] = tbl[i].d[j];
            cur_c[j] = tbl[i].c[j];
            exp_w[j] = tbl[i].w[j];
        end
        exp_c = tbl[i].cy;
    endtask

    initial begin
        // Plain result
        tbl[0].d = '{17'h1FFFF, 17'h0, 17'h0, 17'h0};
        tbl[0].c = '{17'h00001, 17'h0, 17'h0, 17'h0};
        tbl[0].w = '{17'h1FFFF, 17'h00001, 17'h0, 17'h0};
        tbl[0].cy = 18'h0;
        tbl[0].rmode = 0;
        // Worst-case carries, with back-pressure 1,0,0,1
        tbl[1].d = '{17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF};
        tbl[1].c = '{17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF};
        tbl[1].w = '{17'h1FFFF, 17'h1FFFE, 17'h1FFFF, 17'h1FFFF};
        tbl[1].cy = 18'h20000;
        tbl[1].rmode = 1;
        // Mixed carries, random ready
        tbl[2].d = '{17'h00005, 17'h1FFFF, 17'h00007, 17'h10000};
        tbl[2].c = '{17'h1FFFF, 17'h00003, 17'h00000, 17'h1FFFF};
        tbl[2].w = '{17'h00005, 17'h1FFFE, 17'h0000B, 17'h10000};
        tbl[2].cy = 18'h1FFFF;
        tbl[2].rmode = 2;

        // Reset state
        repeat (2) @(posedge clock_i);
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_valid", res_valid_o, 0);
        check("rst_data", res_data_o, 0);
        check("rst_last", res_last_o, 0);
        check("rst_carry", carry_o, 0);
        check("rst_done", done_o, 0);
        check("rst_overrun", overrun_o, 0);
        reset_i = 1'b1;
        tick();

        // digit_valid in IDLE is ignored
        send_digit(17'h1234, 17'h1);
        check("idle_ignores_digit", busy_o, 0);

        for (int i = 0; i < 3; i++) begin
            load_vec(i);
            run_case(tbl[i].rmode, i % 2);
        end

        // Gapped input plus restart in the middle of COLLECT
        do_start();
        send_digit(17'h0AAAA, 17'h00777);
        tick();
        send_digit(17'h15555, 17'h1FFFF);
        start_i = 1'b1;
        digit_valid_i = 1'b1;
        digit_i = 17'h1ABCD;
        carry_i = 17'h1FFFF;
        tick();
        start_i = 1'b0;
        digit_valid_i = 1'b0;
        for (int j = 0; j < 4; j++) begin
            cur_d[j] = 17'(j + 1);
            cur_c[j] = '0;
            exp_w[j] = 17'(j + 1);
        end
        exp_c = '0;
        feed(1);
        drain_check(0);

        // Overrun: digit pulsed during DRAIN, data unchanged, sticky until start in IDLE
        load_vec(2);
        do_start();
        feed(0);
        res_ready_i = 1'b0;
        digit_valid_i = 1'b1;
        digit_i = 17'h0F0F0;
        carry_i = 17'h00F0F;
        tick();
        digit_valid_i = 1'b0;
        check("overrun_set", overrun_o, 1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("start_ignored_in_drain", res_valid_o, 1);
        drain_check(0);
        tick();
        check("done_one_cycle", done_o, 0);
        check("overrun_sticky", overrun_o, 1);
        do_start();
        check("overrun_cleared", overrun_o, 0);

        // Async reset mid-DRAIN after 2 of 4 digits
        load_vec(1);
        do_start();
        feed(0);
        res_ready_i = 1'b1;
        digit_valid_i = 1'b1;
        tick();
        digit_valid_i = 1'b0;
        tick();
        res_ready_i = 1'b0;
        check("pre_reset_overrun", overrun_o, 1);
        #2;
        reset_i = 1'b0;
        #1;
        check("arst_busy", busy_o, 0);
        check("arst_valid", res_valid_o, 0);
        check("arst_data", res_data_o, 0);
        check("arst_last", res_last_o, 0);
        check("arst_carry", carry_o, 0);
        check("arst_overrun", overrun_o, 0);
        tick();
        check("arst_no_done", done_o, 0);
        reset_i = 1'b1;
        tick();
        load_vec(0);
        run_case(0, 0);

        // Randomized results against the integer model
        for (int n = 0; n < 20; n++) begin
            for (int j = 0; j < 4; j++) begin
                cur_d[j] = 17'($urandom);
                cur_c[j] = (n % 4 == 0) ? 17'h1FFFF : 17'($urandom);
            end
            ref_model();
            run_case(2, n % 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
